// File: rtl/delay_line_3lane.sv
// Three independent free-running delay lines. Each lane shifts a
// {data, valid} pair through DEPTH stages every cycle and taps the stage
// selected by its registered delay code, so code N gives N+1 cycles of
// latency. Changing a lane's code drops everything already in flight on
// that lane, so a sample never emerges with a latency it was not launched
// under.
module delay_line_3lane #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 8,
  localparam int DLYW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic             a_valid,
  input  logic             b_valid,
  input  logic             c_valid,
  input  logic [DLYW-1:0]  dly_a,
  input  logic [DLYW-1:0]  dly_b,
  input  logic [DLYW-1:0]  dly_c,
  output logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] e,
  output logic [WIDTH-1:0] f,
  output logic             d_valid,
  output logic             e_valid,
  output logic             f_valid,
  output logic             busy
);

  localparam int LANES = 3;

  logic [WIDTH-1:0] w_inData  [LANES];
  logic             w_inValid [LANES];
  logic [DLYW-1:0]  w_dly     [LANES];
  logic             w_flush   [LANES];

  logic [WIDTH-1:0] w_nextData  [LANES][DEPTH];
  logic             w_nextValid [LANES][DEPTH];
  logic             w_anyValid;

  logic [WIDTH-1:0] w_outData  [LANES];
  logic             w_outValid [LANES];

  logic [WIDTH-1:0] r_data  [LANES][DEPTH];
  logic             r_valid [LANES][DEPTH];
  logic [DLYW-1:0]  r_dlyQ  [LANES];
  logic             r_busy;

  assign w_inData[0]  = a;
  assign w_inData[1]  = b;
  assign w_inData[2]  = c;
  assign w_inValid[0] = a_valid;
  assign w_inValid[1] = b_valid;
  assign w_inValid[2] = c_valid;
  assign w_dly[0]     = dly_a;
  assign w_dly[1]     = dly_b;
  assign w_dly[2]     = dly_c;

  // Next contents of every stage: stage 0 takes the new sample (bubble if
  // not valid), later stages shift unless this edge changes the lane's code.
  always_comb begin
    w_anyValid = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      w_flush[l]          = (w_dly[l] != r_dlyQ[l]);
      w_nextValid[l][0]   = w_inValid[l];
      w_nextData[l][0]    = w_inValid[l] ? w_inData[l] : '0;
      w_anyValid          = w_anyValid | w_nextValid[l][0];
      for (int i = 1; i < DEPTH; i++) begin
        if (w_flush[l]) begin
          w_nextValid[l][i] = 1'b0;
          w_nextData[l][i]  = '0;
        end else begin
          w_nextValid[l][i] = r_valid[l][i-1];
          w_nextData[l][i]  = r_data[l][i-1];
        end
        w_anyValid = w_anyValid | w_nextValid[l][i];
      end
    end
  end

  // Stage, delay-code and busy registers; reset clears everything and wins
  // over loading and flushing.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int l = 0; l < LANES; l++) begin
        r_dlyQ[l] <= '0;
        for (int i = 0; i < DEPTH; i++) begin
          r_valid[l][i] <= 1'b0;
          r_data[l][i]  <= '0;
        end
      end
      r_busy <= 1'b0;
    end else begin
      for (int l = 0; l < LANES; l++) begin
        r_dlyQ[l] <= w_dly[l];
        for (int i = 0; i < DEPTH; i++) begin
          r_valid[l][i] <= w_nextValid[l][i];
          r_data[l][i]  <= w_nextData[l][i];
        end
      end
      r_busy <= w_anyValid;
    end
  end

  // Output tap at the registered code; data is forced to zero on bubbles and
  // codes beyond the last stage read as empty.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      w_outValid[l] = 1'b0;
      w_outData[l]  = '0;
      if (r_dlyQ[l] <= DLYW'(DEPTH - 1)) begin
        w_outValid[l] = r_valid[l][r_dlyQ[l]];
        w_outData[l]  = r_valid[l][r_dlyQ[l]] ? r_data[l][r_dlyQ[l]] : '0;
      end
    end
  end

  assign d       = w_outData[0];
  assign e       = w_outData[1];
  assign f       = w_outData[2];
  assign d_valid = w_outValid[0];
  assign e_valid = w_outValid[1];
  assign f_valid = w_outValid[2];
  assign busy    = r_busy;

endmodule

// File: tb/tb_delay_line_3lane.sv
// Self-checking bench for delay_line_3lane. A history-based model predicts
// every output from the recorded inputs: a lane output after edge t is the
// sample taken at edge t-N (N = code in force after edge t), provided no
// reset hit it and no code change happened after it was taken.
module tb_delay_line_3lane;

  localparam int W    = 3;
  localparam int D    = 8;
  localparam int DW   = 3;
  localparam int MAXE = 2000;

  logic          clk = 1'b0;
  logic          reset;
  logic          inV   [3];
  logic [W-1:0]  inD   [3];
  logic [DW-1:0] inDly [3];
  logic [W-1:0]  dOut, eOut, fOut;
  logic          dV, eV, fV, busyOut;

  int tests  = 0;
  int errors = 0;
  int edgeNo = -1;

  logic          rstH [MAXE];
  logic          vinH [3][MAXE];
  logic [W-1:0]  dinH [3][MAXE];
  logic [DW-1:0] dqH  [3][MAXE];
  logic          flH  [3][MAXE];

  delay_line_3lane #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .reset(reset),
    .a(inD[0]), .b(inD[1]), .c(inD[2]),
    .a_valid(inV[0]), .b_valid(inV[1]), .c_valid(inV[2]),
    .dly_a(inDly[0]), .dly_b(inDly[1]), .dly_c(inDly[2]),
    .d(dOut), .e(eOut), .f(fOut),
    .d_valid(dV), .e_valid(eV), .f_valid(fV),
    .busy(busyOut)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Is the sample taken i edges before edge t still alive after edge t?
  function automatic logic stageValid(int l, int t, int i);
    int s;
    s = t - i;
    if (s < 0) return 1'b0;
    if (!vinH[l][s]) return 1'b0;
    for (int k = s; k <= t; k++) if (rstH[k]) return 1'b0;
    for (int k = s + 1; k <= t; k++) if (flH[l][k]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [W:0] modelOut(int l, int t);
    int n;
    logic v;
    n = int'(dqH[l][t]);
    v = stageValid(l, t, n);
    return v ? {1'b1, dinH[l][t-n]} : {1'b0, {W{1'b0}}};
  endfunction

  function automatic logic modelBusy(int t);
    logic b;
    b = 1'b0;
    for (int l = 0; l < 3; l++)
      for (int i = 0; i < D; i++)
        b = b | stageValid(l, t, i);
    return b;
  endfunction

  function automatic logic [W:0] dutOut(int l);
    case (l)
      0:       return {dV, dOut};
      1:       return {eV, eOut};
      default: return {fV, fOut};
    endcase
  endfunction

  task automatic applyStimulus(int l, logic v, logic [W-1:0] dv, logic [DW-1:0] dl);
    inV[l]   = v;
    inD[l]   = dv;
    inDly[l] = dl;
  endtask

  task automatic record();
    logic [DW-1:0] prev;
    edgeNo++;
    if (edgeNo >= MAXE) begin
      $display("[TB] FAIL edge budget exceeded at edge %0d", edgeNo);
      $fatal(1);
    end
    rstH[edgeNo] = reset;
    for (int l = 0; l < 3; l++) begin
      vinH[l][edgeNo] = inV[l];
      dinH[l][edgeNo] = inD[l];
      dqH[l][edgeNo]  = reset ? '0 : inDly[l];
      prev = '0;
      if (edgeNo > 0) prev = dqH[l][edgeNo-1];
      flH[l][edgeNo] = !reset && (inDly[l] != prev);
    end
  endtask

  task automatic checkOutput();
    logic [W:0] expO, gotO;
    logic expB;
    for (int l = 0; l < 3; l++) begin
      expO = modelOut(l, edgeNo);
      gotO = dutOut(l);
      tests++;
      if (gotO !== expO) begin
        errors++;
        $display("[TB] FAIL lane%0d edge %0d: got v=%0b d=%0d, expected v=%0b d=%0d",
                 l, edgeNo, gotO[W], gotO[W-1:0], expO[W], expO[W-1:0]);
      end
    end
    expB = modelBusy(edgeNo);
    tests++;
    if (busyOut !== expB) begin
      errors++;
      $display("[TB] FAIL busy edge %0d: got %0b, expected %0b", edgeNo, busyOut, expB);
    end
  endtask

  task automatic checkLit(string name, int got, int exp);
    tests++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s edge %0d: got %0d, expected %0d", name, edgeNo, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    record();
    #1;
    checkOutput();
  endtask

  task automatic idleAll();
    for (int l = 0; l < 3; l++) begin
      inV[l] = 1'b0;
      inD[l] = '0;
    end
  endtask

  // Directed scenarios with literal expectations, then a random soak.
  initial begin
    reset = 1'b1;
    for (int l = 0; l < 3; l++) applyStimulus(l, 1'b0, '0, '0);
    step();
    step();
    checkLit("resetLaneA", int'(dutOut(0)), 0);
    checkLit("resetBusy", int'(busyOut), 0);

    // Single sample on lane a with code 3: visible only after edge k+3
    reset = 1'b0;
    applyStimulus(0, 1'b0, '0, 3'd3);
    step();
    applyStimulus(0, 1'b1, 3'b101, 3'd3);
    step();
    checkLit("singleK0", int'(dutOut(0)), 0);
    idleAll();
    step(); checkLit("singleK1", int'(dutOut(0)), 0);
    step(); checkLit("singleK2", int'(dutOut(0)), 0);
    step(); checkLit("singleK3", int'(dutOut(0)), 'b1101);
    step(); checkLit("singleK4", int'(dutOut(0)), 0);

    // Code 0 on lane b: burst of four comes out one cycle later, back to back
    applyStimulus(1, 1'b0, '0, 3'd0);
    step();
    for (int v = 1; v <= 4; v++) begin
      applyStimulus(1, 1'b1, W'(v), 3'd0);
      step();
      checkLit("burstB", int'(dutOut(1)), 8 + v);
    end
    idleAll();
    step();
    checkLit("burstBEnd", int'(dutOut(1)), 0);

    // Code change on lane c flushes c=6; c=5 launched on the change edge uses code 2
    applyStimulus(2, 1'b0, '0, 3'd7);
    step();
    applyStimulus(2, 1'b1, 3'd6, 3'd7);
    step();
    applyStimulus(2, 1'b0, '0, 3'd7);
    step();
    applyStimulus(2, 1'b1, 3'd5, 3'd2);
    step(); checkLit("flushC0", int'(dutOut(2)), 0);
    applyStimulus(2, 1'b0, '0, 3'd2);
    step(); checkLit("flushC1", int'(dutOut(2)), 0);
    step(); checkLit("flushC2", int'(dutOut(2)), 'b1101);
    for (int j = 0; j < 6; j++) begin
      step();
      checkLit("flushCQuiet", int'(dutOut(2)), 0);
    end

    // Same sample on all lanes with codes 1, 4, 7
    reset = 1'b1;
    step();
    reset = 1'b0;
    applyStimulus(0, 1'b0, '0, 3'd1);
    applyStimulus(1, 1'b0, '0, 3'd4);
    applyStimulus(2, 1'b0, '0, 3'd7);
    step();
    for (int l = 0; l < 3; l++) begin
      inV[l] = 1'b1;
      inD[l] = 3'b111;
    end
    step();
    idleAll();
    for (int j = 1; j <= 8; j++) begin
      step();
      checkLit("tapA", int'(dutOut(0)), (j == 1) ? 'hF : 0);
      checkLit("tapB", int'(dutOut(1)), (j == 4) ? 'hF : 0);
      checkLit("tapC", int'(dutOut(2)), (j == 7) ? 'hF : 0);
      if (j >= 7) checkLit("tapBusy", int'(busyOut), (j == 7) ? 1 : 0);
    end

    // Mid-stream reset on lane a with code 5
    for (int j = 0; j < 10; j++) begin
      reset = (j == 4);
      applyStimulus(0, (j < 8), W'(j), 3'd5);
      step();
      if (j >= 4) checkLit("midReset", int'(dutOut(0)), 0);
      if (j == 4) checkLit("midResetBusy", int'(busyOut), 0);
    end
    idleAll();

    // Alternating valid on lane a with code 2
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int j = 0; j < 12; j++) begin
      applyStimulus(0, (j % 2 == 0), W'($urandom_range(0, 7)), 3'd2);
      step();
      if (j >= 2) checkLit("alternate", int'(dV), (j % 2 == 0) ? 1 : 0);
    end
    idleAll();

    // Random soak, checked against the model every cycle
    for (int j = 0; j < 600; j++) begin
      reset = ($urandom_range(0, 63) == 0);
      for (int l = 0; l < 3; l++) begin
        inV[l] = $urandom_range(0, 1) == 1;
        inD[l] = W'($urandom_range(0, 7));
        if ($urandom_range(0, 15) == 0) inDly[l] = DW'($urandom_range(0, D - 1));
      end
      step();
    end
    reset = 1'b0;
    idleAll();
    for (int j = 0; j < 10; j++) step();
    checkLit("drainBusy", int'(busyOut), 0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
